mash_ddsm_param: RTL and testbench
==================================

// Module: mash_ddsm_param
// PURPOSE
//  Parametrised N-stage MASH delta-sigma modulator built from first-order error-feedback accumulators.
//  Generalises the fixed three-chain NCSP MASH:
//   - configurable stage count and accumulator width;
//   - staggered internal reset release, last stage released first;
//   - seed load into stage 1;
//   - on-chip noise-cancellation network giving a registered signed divider-offset word.
//  Drives the fractional-N divider modulus adder; i_frac comes from the channel/fraction register block.
// PARAMETERS
//  P_DATA_WIDTH   8  accumulator width W; fraction resolution 2^-W
//  P_STAGES       3  MASH order N, legal 1..4
//  P_RST_STAGGER  2  cycles between successive stage reset releases, legal 1..4
//  localparam P_OUT_W = P_STAGES+1  signed output width
// PORTS
//  i_clk      in   1          clock
//  i_rst_n    in   1          asynchronous active-low reset
//  i_en       in   1          clock enable; low = freeze all state
//  i_frac     in   W          fractional input, unsigned, sampled every enabled cycle
//  i_seed     in   W          stage-1 seed, sampled on stage-1 release cycle
//  o_carry    out  N          raw per-stage carries c_k, bit k-1 = stage k
//  o_y        out  P_OUT_W    signed cancelled output, two's complement
//  o_valid    out  1          o_y meaningful (all stages released, network filled)
// BEHAVIOUR
//  - Reset:
//    - i_rst_n low asynchronously clears every register: accumulators, carries, delay lines, release tree, o_y, o_valid.
//    - All outputs read 0 during reset. Asserting reset mid-operation behaves identically; no state is preserved.
//  - Release tree: shift register, length L = P_RST_STAGGER*(N-1)+1, shifts in 1 each enabled cycle after i_rst_n rises.
//    - Stage N runs from tree bit 0.
//    - Stage k runs from bit P_RST_STAGGER*(N-k).
//    - A stage not yet released holds acc=0, c=0.
//  - Seed: on the first cycle stage 1 is released, acc1 <= i_seed and c1 <= 0; i_frac is not added that cycle.
//  - Accumulate: every enabled released cycle, registered, no saturation, wrap mod 2^W.
//    - Stage 1: {c1,acc1} <= acc1 + i_frac.
//    - Stage k>1: {ck,acck} <= acck + acc(k-1), using the registered acc of the previous stage.
//  - Alignment: c_k is delayed by (N-k) enabled cycles, giving a_k.
//  - Cancellation: y = sum_k D^(k-1)(a_k), with D(x) = x[n] - x[n-1]. Difference histories clear on reset.
//    - Example N=3: y = a1 + (a2-a2') + (a3-2a3'+a3'').
//    - Range: N=1 0..1, N=2 -1..2, N=3 -3..4, N=4 -7..8. P_OUT_W must hold the range.
//  - o_y is registered: one cycle after the combinational sum.
//  - o_carry shows the current carry registers, not the aligned copies.
//  - o_valid rises N+1 enabled cycles after stage 1 release and stays high until reset.
//  - i_en low: every register including the release tree holds; o_y, o_carry and o_valid hold their values.
//  - Long-run property: mean(o_y) = i_frac/2^W once valid. A change of i_frac reaches o_y N+1 enabled cycles later.
//  - Boundaries:
//    - i_frac=0 with seed 0 gives o_y constantly 0.
//    - i_frac = 2^W-1 never overflows o_y.
//    - A simultaneous seed-load cycle and i_en low means the load waits for the next enabled cycle.
// CONFIGURATION
//  MASH_SPMASH_EN defined: sturdy/SP-MASH coupling. Stage N input becomes acc(N-1) + c1 delayed one cycle (c1 adds 1 LSB).
//    - The cancellation network is unchanged.
//    - Breaks pure periodicity at rational fractions; mean stays i_frac/2^W.
//  MASH_SPMASH_EN undefined: classic MASH; stage N input is acc(N-1) only. Required for bit-exact comparison against the golden model.
// TESTING
//  1. Reset 10 cycles then release, W=8, N=3, frac=0, seed=0 -> o_y=0 every cycle; o_valid high 4 cycles after stage-1 release.
//  2. N=1, frac=8'h80, seed=0 -> o_carry alternates 0,1,0,1; o_y follows 1 cycle later.
//  3. W=8, N=3, frac=64, seed=1, SPMASH off -> 4096-cycle mean of o_y = 0.25 +/-0.002; o_y always within -3..4.
//     The sequence must match the golden C model bit-exact.
//  4. Release order check, N=3, P_RST_STAGGER=2 -> stages 3, 2, 1 leave hold at cycles +1, +3, +5 after i_rst_n rises.
//  5. Drop i_rst_n mid-run, asynchronously between clock edges -> all outputs 0 immediately.
//     Re-release reproduces test 3's sequence exactly.
//  6. i_en low for 7 cycles mid-run -> o_y, o_carry and o_valid frozen.
//     Resuming continues the sequence with no skipped or repeated sample.

Source files
------------

// File: rtl/mash_ddsm_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mash_ddsm_param                                                            |
// | N-stage MASH delta-sigma modulator with staggered release, seed load and   |
// | registered signed cancellation output. MASH_SPMASH_EN selects SP-MASH.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mash_ddsm_param #(
  parameter  int P_DATA_WIDTH  = 8,
  parameter  int P_STAGES      = 3,
  parameter  int P_RST_STAGGER = 2,
  localparam int P_OUT_W       = P_STAGES + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic [P_DATA_WIDTH-1:0]   i_frac,
  input  logic [P_DATA_WIDTH-1:0]   i_seed,
  output logic [P_STAGES-1:0]       o_carry,
  output logic signed [P_OUT_W-1:0] o_y,
  output logic                      o_valid
);

  localparam int c_L   = P_RST_STAGGER * (P_STAGES - 1) + 1;
  localparam int c_HD  = (P_STAGES > 1) ? P_STAGES - 1 : 1;
  localparam int c_VCW = $clog2(P_STAGES) + 1;

  logic [c_L-1:0]          r_tree;
  logic [c_L-1:0]          w_tree_nxt;
  logic                    r_seeded;
  logic [P_DATA_WIDTH-1:0] r_acc [P_STAGES];
  logic [P_STAGES-1:0]     r_c;
  logic [P_STAGES-1:0]     r_hist [c_HD];
  logic [c_VCW-1:0]        r_vcnt;
  logic                    r_valid;
  logic signed [P_OUT_W-1:0] r_y;

  logic [P_STAGES-1:0]     w_run;
  logic [P_DATA_WIDTH-1:0] w_add [P_STAGES];
  logic                    w_cin [P_STAGES];
  logic [P_DATA_WIDTH:0]   w_sum [P_STAGES];
  logic [P_STAGES-1:0]     w_tap [P_STAGES];
  int                      w_ysum;

  function automatic int binom(input int n, input int r);
    int v;
    v = 1;
    for (int t = 0; t < r; t++) v = v * (n - t) / (t + 1);
    return v;
  endfunction

  if (c_L == 1) begin : g_tree_single
    assign w_tree_nxt = 1'b1;
  end else begin : g_tree_multi
    assign w_tree_nxt = {r_tree[c_L-2:0], 1'b1};
  end

  for (genvar gi = 0; gi < P_STAGES; gi++) begin : g_stage
    assign w_run[gi] = r_tree[P_RST_STAGGER*(P_STAGES-1-gi)];
    if (gi == 0) begin : g_in_frac
      assign w_add[gi] = i_frac;
    end else begin : g_in_acc
      assign w_add[gi] = r_acc[gi-1];
    end
`ifdef MASH_SPMASH_EN
    // Last stage also absorbs stage-1 carry delayed one cycle.
    if (gi == P_STAGES - 1 && gi > 0) begin : g_sp_cin
      assign w_cin[gi] = r_hist[0][0];
    end else begin : g_no_cin
      assign w_cin[gi] = 1'b0;
    end
`else
    assign w_cin[gi] = 1'b0;
`endif
    assign w_sum[gi] = {1'b0, r_acc[gi]} + {1'b0, w_add[gi]}
                     + {{P_DATA_WIDTH{1'b0}}, w_cin[gi]};
  end

  // w_tap[d] holds every stage's carry delayed by d enabled cycles.
  assign w_tap[0] = r_c;
  for (genvar gd = 1; gd < P_STAGES; gd++) begin : g_tap
    assign w_tap[gd] = r_hist[gd-1];
  end

  // Stage k+1 contributes D^k of its carry aligned by P_STAGES-1-k cycles.
  always_comb begin
    w_ysum = 0;
    for (int k = 0; k < P_STAGES; k++) begin
      for (int j = 0; j <= k; j++) begin
        if (w_tap[P_STAGES-1-k+j][k]) begin
          if (j % 2 == 1) w_ysum = w_ysum - binom(k, j);
          else            w_ysum = w_ysum + binom(k, j);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tree   <= '0;
      r_seeded <= 1'b0;
      r_c      <= '0;
      for (int i = 0; i < P_STAGES; i++) r_acc[i] <= '0;
      for (int d = 0; d < c_HD; d++) r_hist[d] <= '0;
      r_vcnt   <= '0;
      r_valid  <= 1'b0;
      r_y      <= '0;
    end else if (i_en) begin
      r_tree <= w_tree_nxt;
      for (int i = 0; i < P_STAGES; i++) begin
        if (!w_run[i]) begin
          r_acc[i] <= '0;
          r_c[i]   <= 1'b0;
        end else if (i == 0 && !r_seeded) begin
          r_acc[i] <= i_seed;
          r_c[i]   <= 1'b0;
        end else begin
          r_acc[i] <= w_sum[i][P_DATA_WIDTH-1:0];
          r_c[i]   <= w_sum[i][P_DATA_WIDTH];
        end
      end
      if (w_run[0]) r_seeded <= 1'b1;
      r_hist[0] <= r_c;
      for (int d = 1; d < c_HD; d++) r_hist[d] <= r_hist[d-1];
      if (r_seeded && !r_valid) begin
        if (r_vcnt == c_VCW'(P_STAGES - 1)) r_valid <= 1'b1;
        else                                r_vcnt  <= r_vcnt + 1'b1;
      end
      r_y <= w_ysum[P_OUT_W-1:0];
    end
  end

  assign o_carry = r_c;
  assign o_y     = r_y;
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mash_ddsm_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mash_ddsm_param                                                         |
// | Directed bench: N=3 and N=1 modulators against hand-derived sequences.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mash_ddsm_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       en1 = 1'b0;
  logic [7:0] frac = '0, seed = '0, frac1 = '0, seed1 = '0;
  logic [2:0] carry;
  logic signed [3:0] y;
  logic       valid;
  logic [0:0] carry1;
  logic signed [1:0] y1;
  logic       valid1;

  int n_total = 0;
  int n_bad   = 0;

  // o_y after enabled edge e (frac=64, seed=1, release at e=0)
  int exp_y [9:23] = '{0, 0, 1, -1, 2, -2, 3, -2, 1, 0, 1, -1, 2, -1, 0};
  // {c3,c2,c1} after enabled edge e
  int exp_c [10:22] = '{7, 0, 4, 2, 7, 0, 0, 0, 7, 0, 4, 6, 3};

  always #5 clk = ~clk;

  mash_ddsm_param #(.P_DATA_WIDTH(8), .P_STAGES(3), .P_RST_STAGGER(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_frac(frac), .i_seed(seed),
    .o_carry(carry), .o_y(y), .o_valid(valid)
  );

  mash_ddsm_param #(.P_DATA_WIDTH(8), .P_STAGES(1), .P_RST_STAGGER(2)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en1), .i_frac(frac1), .i_seed(seed1),
    .o_carry(carry1), .o_y(y1), .o_valid(valid1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drops reset between edges and checks outputs clear without a clock edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_carry"}, int'(carry), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_valid1"}, int'(valid1), 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic run_seq(input string tag, input bit freeze);
    frac = 8'd64;
    seed = 8'd1;
    en   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 23; e++) begin
      tick();
      if (e == 8) chk({tag, "_valid_e8"}, int'(valid), 0);
      if (e >= 9) begin
        chk({tag, "_valid"}, int'(valid), 1);
        chk({tag, "_y"}, int'(y), exp_y[e]);
      end
      if (e >= 10 && e <= 22) chk({tag, "_carry"}, int'(carry), exp_c[e]);
      if (freeze && e == 14) begin
        en = 1'b0;
        for (int f = 0; f < 7; f++) begin
          tick();
          chk("freeze_y", int'(y), -2);
          chk("freeze_carry", int'(carry), 7);
          chk("freeze_valid", int'(valid), 1);
        end
        en = 1'b1;
      end
    end
  endtask

  initial begin
    int sum;
    int ymin;
    int ymax;
    en = 1'b1;
    en1 = 1'b1;
    frac1 = 8'h80;
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_y", int'(y), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_y1", int'(y1), 0);

    // Zero input, release order, and the N=1 half-rate pattern.
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk("zero_y", int'(y), 0);
      if (e == 1) chk("tree_e1", int'(u_dut.r_tree), 5'b00001);
      if (e == 3) chk("tree_e3", int'(u_dut.r_tree), 5'b00111);
      if (e == 5) chk("tree_e5", int'(u_dut.r_tree), 5'b11111);
      if (e == 8) chk("zero_valid_e8", int'(valid), 0);
      if (e == 9) chk("zero_valid_e9", int'(valid), 1);
      if (e == 2) chk("n1_valid_e2", int'(valid1), 0);
      if (e == 3) chk("n1_valid_e3", int'(valid1), 1);
      if (e >= 3 && e <= 6) chk("n1_carry", int'(carry1), (e % 2 == 0) ? 1 : 0);
      if (e >= 4 && e <= 7) chk("n1_y", int'(y1), (e % 2 == 1) ? 1 : 0);
    end

    async_reset("rstA");
    run_seq("seq", 1'b1);

    sum = 0;
    ymin = 0;
    ymax = 0;
    for (int n = 0; n < 4096; n++) begin
      tick();
      sum += int'(y);
      if (int'(y) < ymin) ymin = int'(y);
      if (int'(y) > ymax) ymax = int'(y);
    end
    chk("mean_sum_in_1016_1032", int'(sum >= 1016 && sum <= 1032), 1);
    chk("range_m3_p4", int'(ymin >= -3 && ymax <= 4), 1);

    async_reset("rstB");
    run_seq("reseq", 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
